// File: rtl/ram_port2_arbiter.sv
// Arbiter sharing memory port 2 between the load/store unit (m0) and the debug/loader master (m1).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration in IDLE; otherwise m0 has fixed priority.
//
// Handshake: a beat transfers at a posedge where mX_req & mX_gnt are both high. gnt is
// combinational from the current reqs and registered owner state. Request fields must stay
// stable while req is high and gnt is low. Reads return on mX_rvalid exactly one cycle later.
module ram_port2_arbiter #(
   parameter int INST_ADDR_WIDTH = 10,
   parameter int MAX_HOLD        = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic        m0_lock,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic        m1_lock,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_d,
   output logic        ram_we,
   output logic [3:0]  ram_wstrb,
   input  logic [31:0] ram_q,
   output logic [1:0]  fsm_state
);

   localparam int          AW       = INST_ADDR_WIDTH;
   localparam logic [7:0]  HOLD_LIM = 8'(MAX_HOLD);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  hold_cnt, hold_cnt_nxt, hold_inc;
   logic        force_vld, force_vld_nxt;
   logic        force_idx, force_idx_nxt;
   logic        gnt0, gnt1;
   logic        xfer0, xfer1;
   logic        rd_pend, rd_src;
   logic [31:0] sel_addr;

`ifdef ARB_ROUND_ROBIN_EN
   logic        last_winner;
`endif

   assign xfer0    = m0_req & gnt0;
   assign xfer1    = m1_req & gnt1;
   assign hold_inc = hold_cnt + 8'd1;

   // State register, read-return pipeline and arbitration history.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         hold_cnt  <= 8'd0;
         force_vld <= 1'b0;
         force_idx <= 1'b0;
         rd_pend   <= 1'b0;
         rd_src    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_winner <= 1'b1;
`endif
      end else begin
         state     <= state_nxt;
         hold_cnt  <= hold_cnt_nxt;
         force_vld <= force_vld_nxt;
         force_idx <= force_idx_nxt;
         rd_pend   <= (xfer0 & ~m0_we) | (xfer1 & ~m1_we);
         rd_src    <= xfer1;
`ifdef ARB_ROUND_ROBIN_EN
         if (xfer0 | xfer1) last_winner <= xfer1;
`endif
      end
   end

   // Next-state: ownership, hold counting and forced release.
   always_comb begin
      state_nxt     = state;
      hold_cnt_nxt  = hold_cnt;
      force_vld_nxt = force_vld;
      force_idx_nxt = force_idx;
      if (xfer0 | xfer1) force_vld_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (xfer0 && m0_lock) begin
               state_nxt    = ST_OWN0;
               hold_cnt_nxt = 8'd0;
            end else if (xfer1 && m1_lock) begin
               state_nxt    = ST_OWN1;
               hold_cnt_nxt = 8'd0;
            end
         end
         ST_OWN0: begin
            if (xfer0) begin
               if (m1_req) hold_cnt_nxt = hold_inc;
               // Hold limit overrides the lock so m1 cannot be starved.
               if (m1_req && hold_inc >= HOLD_LIM) begin
                  state_nxt     = ST_IDLE;
                  force_vld_nxt = 1'b1;
                  force_idx_nxt = 1'b1;
               end else if (!m0_lock) begin
                  state_nxt = ST_IDLE;
               end
            end else if (!m0_req && !m0_lock) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_OWN1: begin
            if (xfer1) begin
               if (m0_req) hold_cnt_nxt = hold_inc;
               if (m0_req && hold_inc >= HOLD_LIM) begin
                  state_nxt     = ST_IDLE;
                  force_vld_nxt = 1'b1;
                  force_idx_nxt = 1'b0;
               end else if (!m1_lock) begin
                  state_nxt = ST_IDLE;
               end
            end else if (!m1_req && !m1_lock) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Grant decode; both grants are held low throughout reset.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         case (state)
            ST_IDLE: begin
               if (m0_req && m1_req) begin
                  if (force_vld) begin
                     gnt0 = ~force_idx;
                     gnt1 = force_idx;
                  end else begin
`ifdef ARB_ROUND_ROBIN_EN
                     gnt0 = last_winner;
                     gnt1 = ~last_winner;
`else
                     gnt0 = 1'b1;
`endif
                  end
               end else begin
                  gnt0 = m0_req;
                  gnt1 = m1_req;
               end
            end
            ST_OWN0: gnt0 = m0_req;
            ST_OWN1: gnt1 = m1_req;
            default: ;
         endcase
      end
   end

   assign m0_gnt = gnt0;
   assign m1_gnt = gnt1;

   // Address fields outside the memory's word index pass through untouched.
   assign sel_addr  = gnt1 ? m1_addr : m0_addr;
   assign ram_addr  = {sel_addr[31:AW+2], sel_addr[AW+1:2], sel_addr[1:0]};
   assign ram_d     = gnt1 ? m1_wdata : m0_wdata;
   assign ram_we    = (gnt1 & m1_we) | (gnt0 & m0_we);
   assign ram_wstrb = gnt1 ? m1_wstrb : (gnt0 ? m0_wstrb : 4'd0);

   assign m0_rvalid = rd_pend & ~rd_src & ~reset;
   assign m1_rvalid = rd_pend &  rd_src & ~reset;
   assign m0_rdata  = ram_q;
   assign m1_rdata  = ram_q;
   assign fsm_state = state;

endmodule
